// File: rtl/spi_msg_forwarder_if.sv
// -----------------------------------------------------------------------------
// spi_msg_forwarder_if
// Bundles the handshake signals between the message forwarder, the receive
// side of the source spi_process (length/data FIFOs) and the transmit
// serializer of the sink spi_process.
//   GOT_FULL_MSG : source holds at least one complete message
//   RD_REQ_LEN   : pop of the source length FIFO
//   MSG_LEN      : popped length (valid the cycle after RD_REQ_LEN)
//   RD_REQ       : pop of the source data FIFO
//   FIFO_Q       : popped payload word (valid the cycle after RD_REQ)
//   DATA / ENA   : word presented to the sink and its accept strobe
//   BUSY         : sink serializer busy (may be asynchronous)
//   ACTIVE       : forwarder is not idle
//   DROP         : oversize message drained and discarded
//   MSG_CNT      : forwarded message count
// Modports: master = forwarder side, slave = source/sink environment side.
// -----------------------------------------------------------------------------
interface spi_msg_forwarder_if;
  logic        GOT_FULL_MSG;
  logic        RD_REQ_LEN;
  logic [7:0]  MSG_LEN;
  logic        RD_REQ;
  logic [15:0] FIFO_Q;
  logic [15:0] DATA;
  logic        ENA;
  logic        BUSY;
  logic        ACTIVE;
  logic        DROP;
  logic [15:0] MSG_CNT;

  modport master (
    input  GOT_FULL_MSG, MSG_LEN, FIFO_Q, BUSY,
    output RD_REQ_LEN, RD_REQ, DATA, ENA, ACTIVE, DROP, MSG_CNT
  );

  modport slave (
    output GOT_FULL_MSG, MSG_LEN, FIFO_Q, BUSY,
    input  RD_REQ_LEN, RD_REQ, DATA, ENA, ACTIVE, DROP, MSG_CNT
  );
endinterface

// File: rtl/spi_msg_forwarder.sv
// -----------------------------------------------------------------------------
// spi_msg_forwarder
// Forwards complete messages from the receive FIFOs of one SPI link to the
// transmit serializer of another. Waits for GOT_FULL_MSG, pops the length,
// then moves each payload word with the DATA/ENA/BUSY handshake. Messages
// longer than MAX_LEN are popped and discarded (DROP pulse).
// Ports:
//   SYS_CLK : system clock, rising edge
//   RST     : asynchronous active-low reset
//   bus     : spi_msg_forwarder_if.master (FIFO pops, sink handshake, status)
// Parameters:
//   MAX_LEN    : largest forwarded payload in 16-bit words (1..255)
//   BUSY_GUARD : cycles after each ENA during which BUSY is ignored (1..7)
// Build option:
//   SPI_FWD_HEADER_EN : when defined, every forwarded message is preceded by
//                       a header word {8'hA5, length} with its own ENA.
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_msg_forwarder #(
  parameter int unsigned MAX_LEN    = 64,
  parameter int unsigned BUSY_GUARD = 2
) (
  input  logic                SYS_CLK,
  input  logic                RST,
  spi_msg_forwarder_if.master bus
);

  localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);
  localparam logic [2:0] GUARD_C   = 3'(BUSY_GUARD);

  // IDLE issues the length pop; the registered RD_REQ_LEN is high during
  // S_LEN_REQ and MSG_LEN becomes valid one cycle later, in S_LEN_WAIT.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LEN_REQ   = 4'd1,
    S_LEN_WAIT  = 4'd2,
    S_CHECK     = 4'd3,
    S_READ      = 4'd4,
    S_DATA_WAIT = 4'd5,
    S_SEND      = 4'd6,
    S_DRAIN     = 4'd7,
    S_DONE      = 4'd8
`ifdef SPI_FWD_HEADER_EN
    , S_HDR     = 4'd9
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  rem_q, rem_d;
  logic [2:0]  guard_q, guard_d;
  logic        busy_meta_q, busy_sync_q;
  logic        rd_req_len_q, rd_req_len_d;
  logic        rd_req_q, rd_req_d;
  logic        ena_q, ena_d;
  logic        active_q, active_d;
  logic        drop_q, drop_d;
  logic [15:0] data_q, data_d;
  logic [15:0] msg_cnt_q, msg_cnt_d;
  logic        ready_s;
  logic        at_sink_s;

  // ENA is registered, so the decision is taken one cycle ahead: the guard
  // must have reached 0 by the cycle in which ENA is actually high.
  assign ready_s = !busy_sync_q && (guard_q <= 3'd1);

`ifdef SPI_FWD_HEADER_EN
  assign at_sink_s = (state_d == S_SEND) || (state_d == S_HDR);
`else
  assign at_sink_s = (state_d == S_SEND);
`endif

  // State register, datapath registers, output registers and BUSY synchronizer
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      len_q        <= 8'd0;
      rem_q        <= 8'd0;
      guard_q      <= 3'd0;
      busy_meta_q  <= 1'b0;
      busy_sync_q  <= 1'b0;
      rd_req_len_q <= 1'b0;
      rd_req_q     <= 1'b0;
      ena_q        <= 1'b0;
      active_q     <= 1'b0;
      drop_q       <= 1'b0;
      data_q       <= 16'd0;
      msg_cnt_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      guard_q      <= guard_d;
      busy_meta_q  <= bus.BUSY;
      busy_sync_q  <= busy_meta_q;
      rd_req_len_q <= rd_req_len_d;
      rd_req_q     <= rd_req_d;
      ena_q        <= ena_d;
      active_q     <= active_d;
      drop_q       <= drop_d;
      data_q       <= data_d;
      msg_cnt_q    <= msg_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.GOT_FULL_MSG) begin
          state_d = S_LEN_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN_REQ:  state_d = S_LEN_WAIT;
      S_LEN_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        if (len_q == 8'd0) begin
          state_d = S_IDLE;
        end else if (len_q > MAX_LEN_C) begin
          state_d = S_DRAIN;
        end else begin
`ifdef SPI_FWD_HEADER_EN
          state_d = S_HDR;
`else
          state_d = S_READ;
`endif
        end
      end
`ifdef SPI_FWD_HEADER_EN
      S_HDR: begin
        if (ena_q) begin
          state_d = S_READ;
        end else begin
          state_d = S_HDR;
        end
      end
`endif
      S_READ:      state_d = S_DATA_WAIT;
      S_DATA_WAIT: state_d = S_SEND;
      // ena_q high means the word was handed over in this cycle
      S_SEND: begin
        if (!ena_q) begin
          state_d = S_SEND;
        end else if (rem_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        if (rem_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    rd_req_len_d = (state_d == S_LEN_REQ);
    rd_req_d     = (state_d == S_READ) || (state_d == S_DRAIN);
    active_d     = (state_d != S_IDLE);
    ena_d        = at_sink_s && ready_s && !ena_q;
    msg_cnt_d    = (state_q == S_DONE) ? (msg_cnt_q + 16'd1) : msg_cnt_q;

    if (state_q == S_LEN_WAIT) begin
      len_d = bus.MSG_LEN;
    end else begin
      len_d = len_q;
    end

    // rem counts words still to be popped
    case (state_q)
      S_LEN_WAIT: rem_d = bus.MSG_LEN;
      S_CHECK:    rem_d = (state_d == S_DRAIN) ? (len_q - 8'd1) : rem_q;
      S_READ:     rem_d = rem_q - 8'd1;
      S_DRAIN:    rem_d = (rem_q != 8'd0) ? (rem_q - 8'd1) : rem_q;
      default:    rem_d = rem_q;
    endcase

    drop_d = (state_d == S_DRAIN) && (rem_d == 8'd0);

    if (state_q == S_DATA_WAIT) begin
      data_d = bus.FIFO_Q;
`ifdef SPI_FWD_HEADER_EN
    end else if ((state_q == S_CHECK) && (state_d == S_HDR)) begin
      data_d = {8'hA5, len_q};
`endif
    end else begin
      data_d = data_q;
    end

    if (ena_d) begin
      guard_d = GUARD_C;
    end else if (guard_q != 3'd0) begin
      guard_d = guard_q - 3'd1;
    end else begin
      guard_d = 3'd0;
    end
  end

  assign bus.RD_REQ_LEN = rd_req_len_q;
  assign bus.RD_REQ     = rd_req_q;
  assign bus.DATA       = data_q;
  assign bus.ENA        = ena_q;
  assign bus.ACTIVE     = active_q;
  assign bus.DROP       = drop_q;
  assign bus.MSG_CNT    = msg_cnt_q;

endmodule

// File: tb/tb_spi_msg_forwarder.sv
// -----------------------------------------------------------------------------
// tb_spi_msg_forwarder
// Directed bench for spi_msg_forwarder (MAX_LEN=4, BUSY_GUARD=2). A small
// source model serves the length/data FIFOs with one-cycle latency and logs
// every output event with its cycle index; each test task compares the log
// against hand-derived values. Cycle index n denotes the cycle following
// rising edge n.
// -----------------------------------------------------------------------------
module tb_spi_msg_forwarder;

`ifdef SPI_FWD_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_cnt = 0;

  logic [7:0]  lq[$];
  logic [15:0] dq[$];
  logic        pend_len = 1'b0;
  logic        pend_dat = 1'b0;

  int          ena_t[$];
  logic [15:0] ena_v[$];
  int          rdl_t[$];
  int          rd_t[$];
  int          drop_t[$];
  int          last_act = 0;
  int          both_cnt = 0;

  spi_msg_forwarder_if intf ();

  spi_msg_forwarder #(.MAX_LEN(4), .BUSY_GUARD(2)) dut (
    .SYS_CLK (clk),
    .RST     (rst_n),
    .bus     (intf)
  );

  always #5 clk = ~clk;

  // Source FIFO model and output event logger
  initial begin
    intf.GOT_FULL_MSG = 1'b0;
    intf.MSG_LEN      = 8'hEE;
    intf.FIFO_Q       = 16'hBAD0;
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (pend_len && lq.size() != 0) intf.MSG_LEN = lq.pop_front();
      else intf.MSG_LEN = 8'hEE;
      if (pend_dat && dq.size() != 0) intf.FIFO_Q = dq.pop_front();
      else intf.FIFO_Q = 16'hBAD0;
      intf.GOT_FULL_MSG = (lq.size() != 0);
      pend_len = intf.RD_REQ_LEN;
      pend_dat = intf.RD_REQ;
      if (intf.ENA) begin
        ena_t.push_back(cyc);
        ena_v.push_back(intf.DATA);
      end
      if (intf.RD_REQ_LEN) rdl_t.push_back(cyc);
      if (intf.RD_REQ) rd_t.push_back(cyc);
      if (intf.DROP) drop_t.push_back(cyc);
      if (intf.ACTIVE) last_act = cyc;
      if (intf.RD_REQ && intf.RD_REQ_LEN) both_cnt = both_cnt + 1;
    end
  end

  task automatic clear_log();
    ena_t.delete(); ena_v.delete(); rdl_t.delete(); rd_t.delete(); drop_t.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (intf.RD_REQ_LEN !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req_len: got %b want 0", intf.RD_REQ_LEN); end
    n_chk++; if (intf.RD_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b want 0", intf.RD_REQ); end
    n_chk++; if (intf.DATA !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", intf.DATA); end
    n_chk++; if (intf.ENA !== 1'b0) begin n_fail++; $display("FAIL reset_ena: got %b want 0", intf.ENA); end
    n_chk++; if (intf.ACTIVE !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", intf.ACTIVE); end
    n_chk++; if (intf.DROP !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", intf.DROP); end
    n_chk++; if (intf.MSG_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_msg_cnt: got %0d want 0", intf.MSG_CNT); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (intf.ACTIVE !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b want 0", intf.ACTIVE); end
  endtask

  task automatic test_basic();
    int c;
    logic [15:0] w [3];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    clear_log();
    lq.push_back(8'd3);
    for (int i = 0; i < 3; i++) dq.push_back(w[i]);
    c = cyc;
    repeat (40) @(negedge clk);
    exp_cnt = exp_cnt + 1;
    n_chk++; if (rdl_t.size() !== 1) begin n_fail++; $display("FAIL basic_rdlen_count: got %0d want 1", rdl_t.size()); end
    else begin
      n_chk++; if (rdl_t[0] !== c + 2) begin n_fail++; $display("FAIL basic_rdlen_time: got %0d want %0d", rdl_t[0], c + 2); end
    end
    n_chk++; if (rd_t.size() !== 3) begin n_fail++; $display("FAIL basic_rdreq_count: got %0d want 3", rd_t.size()); end
    else begin
      n_chk++; if (rd_t[0] !== c + 5 + HDR) begin n_fail++; $display("FAIL basic_rdreq_time: got %0d want %0d", rd_t[0], c + 5 + HDR); end
    end
    n_chk++; if (ena_t.size() !== 3 + HDR) begin n_fail++; $display("FAIL basic_ena_count: got %0d want %0d", ena_t.size(), 3 + HDR); end
    else begin
      n_chk++; if (ena_t[HDR] !== c + 7 + HDR) begin n_fail++; $display("FAIL basic_ena_first: got %0d want %0d", ena_t[HDR], c + 7 + HDR); end
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (ena_v[HDR + i] !== w[i]) begin n_fail++; $display("FAIL basic_data%0d: got %h want %h", i, ena_v[HDR + i], w[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        n_chk++; if (ena_t[HDR + i] - ena_t[HDR + i - 1] !== 3) begin n_fail++; $display("FAIL basic_spacing%0d: got %0d want 3", i, ena_t[HDR + i] - ena_t[HDR + i - 1]); end
      end
`ifdef SPI_FWD_HEADER_EN
      n_chk++; if (ena_v[0] !== 16'hA503) begin n_fail++; $display("FAIL basic_header: got %h want a503", ena_v[0]); end
      n_chk++; if (ena_t[0] !== c + 5) begin n_fail++; $display("FAIL basic_header_time: got %0d want %0d", ena_t[0], c + 5); end
`endif
    end
    n_chk++; if (intf.MSG_CNT !== 16'(exp_cnt)) begin n_fail++; $display("FAIL basic_msg_cnt: got %0d want %0d", intf.MSG_CNT, exp_cnt); end
    n_chk++; if (drop_t.size() !== 0) begin n_fail++; $display("FAIL basic_drop: got %0d want 0", drop_t.size()); end
  endtask

  task automatic test_zero_len();
    int c;
    clear_log();
    lq.push_back(8'd0);
    c = cyc;
    repeat (20) @(negedge clk);
    n_chk++; if (rdl_t.size() !== 1) begin n_fail++; $display("FAIL zero_rdlen_count: got %0d want 1", rdl_t.size()); end
    n_chk++; if (rd_t.size() !== 0) begin n_fail++; $display("FAIL zero_rdreq: got %0d want 0", rd_t.size()); end
    n_chk++; if (ena_t.size() !== 0) begin n_fail++; $display("FAIL zero_ena: got %0d want 0", ena_t.size()); end
    n_chk++; if (last_act !== c + 4) begin n_fail++; $display("FAIL zero_idle_time: last active %0d want %0d", last_act, c + 4); end
    n_chk++; if (intf.MSG_CNT !== 16'(exp_cnt)) begin n_fail++; $display("FAIL zero_msg_cnt: got %0d want %0d", intf.MSG_CNT, exp_cnt); end
  endtask

  task automatic test_drain();
    int c;
    clear_log();
    lq.push_back(8'd10);
    for (int i = 0; i < 10; i++) dq.push_back(16'h0D00 + 16'(i));
    c = cyc;
    repeat (30) @(negedge clk);
    n_chk++; if (rd_t.size() !== 10) begin n_fail++; $display("FAIL drain_rdreq_count: got %0d want 10", rd_t.size()); end
    else begin
      n_chk++; if (rd_t[0] !== c + 5) begin n_fail++; $display("FAIL drain_first_pop: got %0d want %0d", rd_t[0], c + 5); end
      n_chk++; if (rd_t[9] !== c + 14) begin n_fail++; $display("FAIL drain_last_pop: got %0d want %0d", rd_t[9], c + 14); end
    end
    n_chk++; if (ena_t.size() !== 0) begin n_fail++; $display("FAIL drain_ena: got %0d want 0", ena_t.size()); end
    n_chk++; if (drop_t.size() !== 1) begin n_fail++; $display("FAIL drain_drop_count: got %0d want 1", drop_t.size()); end
    else begin
      n_chk++; if (drop_t[0] !== c + 14) begin n_fail++; $display("FAIL drain_drop_time: got %0d want %0d", drop_t[0], c + 14); end
    end
    n_chk++; if (intf.MSG_CNT !== 16'(exp_cnt)) begin n_fail++; $display("FAIL drain_msg_cnt: got %0d want %0d", intf.MSG_CNT, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    lq.push_back(8'd1); lq.push_back(8'd1);
    dq.push_back(16'hAAAA); dq.push_back(16'h5555);
    repeat (40) @(negedge clk);
    exp_cnt = exp_cnt + 2;
    n_chk++; if (rdl_t.size() !== 2) begin n_fail++; $display("FAIL b2b_rdlen_count: got %0d want 2", rdl_t.size()); end
    else begin
      n_chk++; if (rdl_t[1] - rdl_t[0] !== 8 + HDR) begin n_fail++; $display("FAIL b2b_rdlen_gap: got %0d want %0d", rdl_t[1] - rdl_t[0], 8 + HDR); end
    end
    n_chk++; if (ena_t.size() !== 2 + 2 * HDR) begin n_fail++; $display("FAIL b2b_ena_count: got %0d want %0d", ena_t.size(), 2 + 2 * HDR); end
    else begin
      n_chk++; if (ena_v[HDR] !== 16'hAAAA) begin n_fail++; $display("FAIL b2b_data0: got %h want aaaa", ena_v[HDR]); end
      n_chk++; if (ena_v[1 + 2 * HDR] !== 16'h5555) begin n_fail++; $display("FAIL b2b_data1: got %h want 5555", ena_v[1 + 2 * HDR]); end
    end
    n_chk++; if (intf.MSG_CNT !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b_msg_cnt: got %0d want %0d", intf.MSG_CNT, exp_cnt); end
  endtask

  task automatic test_busy_stall();
    int c2;
    intf.BUSY = 1'b1;
    repeat (3) @(negedge clk);
    clear_log();
    lq.push_back(8'd2);
    dq.push_back(16'h7777); dq.push_back(16'h8888);
    repeat (20) @(negedge clk);
    n_chk++; if (ena_t.size() !== 0) begin n_fail++; $display("FAIL stall_ena: got %0d want 0", ena_t.size()); end
    n_chk++; if (rd_t.size() !== 1 - HDR) begin n_fail++; $display("FAIL stall_rdreq: got %0d want %0d", rd_t.size(), 1 - HDR); end
    n_chk++; if (intf.ACTIVE !== 1'b1) begin n_fail++; $display("FAIL stall_active: got %b want 1", intf.ACTIVE); end
    intf.BUSY = 1'b0;
    c2 = cyc;
    repeat (30) @(negedge clk);
    exp_cnt = exp_cnt + 1;
    n_chk++; if (ena_t.size() !== 2 + HDR) begin n_fail++; $display("FAIL stall_ena_count: got %0d want %0d", ena_t.size(), 2 + HDR); end
    else begin
      n_chk++; if (ena_t[0] !== c2 + 3) begin n_fail++; $display("FAIL stall_release_time: got %0d want %0d", ena_t[0], c2 + 3); end
      n_chk++; if (ena_v[HDR] !== 16'h7777) begin n_fail++; $display("FAIL stall_data0: got %h want 7777", ena_v[HDR]); end
      n_chk++; if (ena_v[HDR + 1] !== 16'h8888) begin n_fail++; $display("FAIL stall_data1: got %h want 8888", ena_v[HDR + 1]); end
`ifdef SPI_FWD_HEADER_EN
      n_chk++; if (ena_v[0] !== 16'hA502) begin n_fail++; $display("FAIL stall_header: got %h want a502", ena_v[0]); end
`endif
    end
    n_chk++; if (rd_t.size() !== 2) begin n_fail++; $display("FAIL stall_rdreq_total: got %0d want 2", rd_t.size()); end
    n_chk++; if (intf.MSG_CNT !== 16'(exp_cnt)) begin n_fail++; $display("FAIL stall_msg_cnt: got %0d want %0d", intf.MSG_CNT, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] held;
    held = (HDR != 0) ? 16'hA503 : 16'hC001;
    intf.BUSY = 1'b1;
    repeat (3) @(negedge clk);
    lq.push_back(8'd3);
    dq.push_back(16'hC001); dq.push_back(16'hC002); dq.push_back(16'hC003);
    repeat (15) @(negedge clk);
    n_chk++; if (intf.DATA !== held) begin n_fail++; $display("FAIL mid_held_data: got %h want %h", intf.DATA, held); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (intf.DATA !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_data: got %h want 0000", intf.DATA); end
    n_chk++; if (intf.ACTIVE !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active: got %b want 0", intf.ACTIVE); end
    n_chk++; if (intf.MSG_CNT !== 16'd0) begin n_fail++; $display("FAIL mid_rst_msg_cnt: got %0d want 0", intf.MSG_CNT); end
    n_chk++; if ({intf.RD_REQ_LEN, intf.RD_REQ, intf.ENA, intf.DROP} !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_strobes: got %b want 0000", {intf.RD_REQ_LEN, intf.RD_REQ, intf.ENA, intf.DROP}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lq.delete(); dq.delete();
    intf.BUSY = 1'b0;
    repeat (4) @(negedge clk);
    clear_log();
    lq.push_back(8'd1);
    dq.push_back(16'h4444);
    repeat (30) @(negedge clk);
    n_chk++; if (ena_t.size() !== 1 + HDR) begin n_fail++; $display("FAIL mid_after_ena_count: got %0d want %0d", ena_t.size(), 1 + HDR); end
    else begin
      n_chk++; if (ena_v[HDR] !== 16'h4444) begin n_fail++; $display("FAIL mid_after_data: got %h want 4444", ena_v[HDR]); end
    end
    n_chk++; if (intf.MSG_CNT !== 16'd1) begin n_fail++; $display("FAIL mid_after_msg_cnt: got %0d want 1", intf.MSG_CNT); end
  endtask

  initial begin
    intf.BUSY = 1'b0;
    test_reset();
    test_basic();
    test_zero_len();
    test_drain();
    test_back_to_back();
    test_busy_stall();
    test_reset_mid();
    n_chk++; if (both_cnt !== 0) begin n_fail++; $display("FAIL rdreq_overlap: got %0d want 0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_msg_forwarder.md
# spi_msg_forwarder

Moves complete messages from the receive side of one `spi_process` instance to the transmit side of another, so the board can redirect traffic between SPI links. It waits for `GOT_FULL_MSG`, pops the length, then reads each payload word from the receive FIFO and hands it to the transmit serializer with the `DATA`/`ENA`/`BUSY` handshake. Oversize messages are drained and dropped. It runs entirely in the `SYS_CLK` domain.

## Interface

- `MAX_LEN`, default 64: largest forwarded payload, in 16-bit words. Legal range 1..255.
- `BUSY_GUARD`, default 2: number of cycles after each `ENA` during which `BUSY` is ignored. Legal range 1..7.

Ports:

- `SYS_CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `GOT_FULL_MSG`  in  1  the source holds at least one complete message.
- `RD_REQ_LEN`  out  1  one-cycle pop of the source length FIFO.
- `MSG_LEN`  in  8  message length in words; valid on the cycle after `RD_REQ_LEN`.
- `RD_REQ`  out  1  one-cycle pop of the source data FIFO.
- `FIFO_Q`  in  16  payload word; valid on the cycle after `RD_REQ`.
- `DATA`  out  16  word presented to the sink; held until the next `ENA`.
- `ENA`  out  1  one-cycle strobe: sink accepts `DATA`.
- `BUSY`  in  1  sink serializer busy; may be asynchronous to `SYS_CLK`, so it is double-flopped internally.
- `ACTIVE`  out  1  high whenever the state is not IDLE.
- `DROP`  out  1  one-cycle pulse when an oversize message has been drained.
- `MSG_CNT`  out  16  count of forwarded messages; wraps modulo 2^16.

## Operation

- All outputs are registered.
- Reset values: `RD_REQ_LEN`=0, `RD_REQ`=0, `DATA`=0, `ENA`=0, `ACTIVE`=0, `DROP`=0, `MSG_CNT`=0.
- Reset forces the state to IDLE and clears the length register, the remaining-word counter and the guard counter.

State machine:

- IDLE: when `GOT_FULL_MSG`=1, pulse `RD_REQ_LEN` and go to LEN_WAIT.
- LEN_WAIT: latch `MSG_LEN` into `len_r`, load `rem`=`MSG_LEN`, go to CHECK.
- CHECK:
  - `len_r`=0: go to IDLE. Nothing is sent and `MSG_CNT` is unchanged.
  - `len_r`>`MAX_LEN`: go to DRAIN.
  - Otherwise: go to HDR if the header feature is compiled in, else READ.
- HDR: wait until the sink is ready, then emit the header word, then go to READ.
- READ: pulse `RD_REQ`, decrement `rem`, go to DATA_WAIT.
- DATA_WAIT: latch `FIFO_Q` into the output register, go to SEND.
- SEND: wait until the sink is ready, then pulse `ENA`. Go to DONE if `rem`=0, else READ.
- DRAIN: pulse `RD_REQ` on every cycle until `len_r` words have been popped; `ENA` is never asserted. On the final cycle pulse `DROP`, then go to IDLE.
- DONE: increment `MSG_CNT`, go to IDLE.

Rules:

- The sink is ready when the synchronized `BUSY`=0 and the guard counter is 0. Every `ENA` reloads the guard counter with `BUSY_GUARD`; it then decrements each cycle down to 0.
- `RD_REQ` and `RD_REQ_LEN` are never asserted together.
- `RD_REQ_LEN` is never asserted outside IDLE.
- `GOT_FULL_MSG` is ignored while a message is in progress.
- `BUSY` stuck high stalls the block in SEND or HDR indefinitely. There is no timeout and no FIFO read happens while stalled.

## Timing

- FIFO read latency is 1 cycle for both length and data.
- With `GOT_FULL_MSG` sampled high at edge k:
  - `RD_REQ_LEN` is high in cycle k+1.
  - `MSG_LEN` is sampled at edge k+2.
  - With the header feature off and the sink idle, the first `RD_REQ` is high in cycle k+4 and the first `ENA` in cycle k+6.
- Minimum spacing between consecutive `ENA` pulses is 3 cycles (READ, DATA_WAIT, SEND), provided `BUSY` stays low and `BUSY_GUARD`≤3.
- The `BUSY` synchronizer adds 2 cycles before a `BUSY` change is seen.
- `DRAIN` of an N-word message takes N cycles.
- After DONE or DRAIN, IDLE can issue the next `RD_REQ_LEN` 1 cycle later.
- Reset asserted mid-message leaves the source FIFO partially read. Recovery is the source's responsibility, since it shares `RST`.

## Configuration

- `SPI_FWD_HEADER_EN` defined: the HDR state exists.
  - Each forwarded message is prefixed by one header word {8'hA5, `len_r`} sent with its own `ENA`.
  - An N-word message produces N+1 `ENA` pulses.
  - First-`ENA` latency is k+4; the first payload `ENA` follows 3 cycles after the header, or later if the sink is busy.
- Not defined: HDR is absent and CHECK goes straight to READ. Only payload words are sent.

## Test plan

- Header off, `BUSY`=0, one 3-word message 16'h1111, 16'h2222, 16'h3333 → exactly 3 `ENA` pulses, 3 cycles apart, `DATA` in that order; 1 `RD_REQ_LEN`, 3 `RD_REQ`; `MSG_CNT`=1.
- `MSG_LEN`=0 → no `RD_REQ`, no `ENA`, `MSG_CNT` unchanged; back in IDLE 3 cycles after `RD_REQ_LEN`.
- `MAX_LEN`=4, `MSG_LEN`=10 → 10 consecutive `RD_REQ`, no `ENA`, one `DROP` pulse on the last pop; `MSG_CNT` unchanged.
- `BUSY` held high for 20 cycles during a 2-word message → `ENA` withheld until `BUSY` has been low for 2 synchronized cycles; no extra `RD_REQ` while stalled.
- `SPI_FWD_HEADER_EN` defined, 2-word message → `ENA` sequence 16'hA502, payload0, payload1.
- `RST` low in the middle of SEND → all outputs return to reset values immediately, state IDLE; the next `GOT_FULL_MSG` is serviced normally.
